// File: rtl/fft_stage_sequencer_if.sv
// Bundles the sequencer's control inputs and its RAM/ROM address outputs.
// Latency: none, wiring only.
// Backpressure: i_stall travels in this bundle toward the sequencer.
interface fft_stage_sequencer_if #(
    parameter int FFT_SIZE       = 8,
    parameter int ADDR_SIZE      = $clog2(2*FFT_SIZE),
    parameter int TWID_ADDR_SIZE = 7,
    parameter int LAYER_W        = $clog2($clog2(FFT_SIZE))
) ();
    logic                      i_start;
    logic                      i_inverse;
    logic                      i_stall;
    logic                      o_busy;
    logic                      o_done;
    logic [LAYER_W-1:0]        o_layer;
    logic                      o_rden;
    logic [ADDR_SIZE-1:0]      o_rdaddr_A;
    logic [ADDR_SIZE-1:0]      o_rdaddr_B;
    logic [TWID_ADDR_SIZE-1:0] o_rdaddr_tw;
    logic                      o_tw_conj;
    logic                      o_wren;
    logic [ADDR_SIZE-1:0]      o_wraddr_A;
    logic [ADDR_SIZE-1:0]      o_wraddr_B;
    logic                      o_result_bank;

    modport master (
        input  i_start, i_inverse, i_stall,
        output o_busy, o_done, o_layer, o_rden, o_rdaddr_A, o_rdaddr_B,
               o_rdaddr_tw, o_tw_conj, o_wren, o_wraddr_A, o_wraddr_B,
               o_result_bank
    );

    modport slave (
        output i_start, i_inverse, i_stall,
        input  o_busy, o_done, o_layer, o_rden, o_rdaddr_A, o_rdaddr_B,
               o_rdaddr_tw, o_tw_conj, o_wren, o_wraddr_A, o_wraddr_B,
               o_result_bank
    );
endinterface

// File: rtl/fft_stage_sequencer.sv
// Radix-2 DIT FFT address sequencer over a ping-pong RAM, all layers per start.
// Latency: first read 1 cycle after start; each write BFLY_LATENCY unstalled cycles after its read.
// Backpressure: i_stall freezes counters and write pipe and masks both strobes.
module fft_stage_sequencer #(
    parameter int FFT_SIZE       = 8,
    parameter int ADDR_SIZE      = $clog2(2*FFT_SIZE),
    parameter int TWID_ADDR_SIZE = 7,
    parameter int BFLY_LATENCY   = 3,
    parameter int LAYER_W        = $clog2($clog2(FFT_SIZE))
) (
    input  logic                         i_CLK,
    input  logic                         i_RST,
    fft_stage_sequencer_if.master        bus
);
    localparam int NUM_LAYERS = $clog2(FFT_SIZE);
    localparam int OW         = $clog2(FFT_SIZE);
    localparam int KW         = OW - 1;
    localparam int DW         = $clog2(BFLY_LATENCY + 1);
    localparam int TWW        = TWID_ADDR_SIZE + OW;

    localparam logic [KW-1:0]      K_LAST      = KW'(FFT_SIZE/2 - 1);
    localparam logic [DW-1:0]      D_LAST      = DW'(BFLY_LATENCY - 1);
    localparam logic [LAYER_W-1:0] LAST_LAYER  = LAYER_W'(NUM_LAYERS - 1);
    localparam logic               RESULT_BANK = 1'(NUM_LAYERS % 2);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    typedef struct packed {
        logic          vld;
        logic          bank;
        logic [OW-1:0] a;
        logic [OW-1:0] b;
    } wr_ent_t;

    state_t             state, state_nxt;
    logic [KW-1:0]      k, k_nxt;
    logic [LAYER_W-1:0] layer, layer_nxt;
    logic [DW-1:0]      drain_cnt, drain_nxt;
    logic               conj, conj_nxt;
    logic               rden;
    logic               busy;
    logic               done;

    wr_ent_t            wr_pipe [BFLY_LATENCY];
    wr_ent_t            wr_in;
    wr_ent_t            wr_tail;

    logic [OW-1:0]      k_ext;
    logic [OW-1:0]      half;
    logic [OW-1:0]      pos;
    logic [OW-1:0]      a_off;
    logic [OW-1:0]      b_off;
    logic [TWW-1:0]     tw_wide;

    // Butterfly geometry for (layer, k); B sits exactly one half-span above A.
    always_comb begin
        k_ext   = {1'b0, k};
        half    = OW'(1) << layer;
        pos     = k_ext & (half - OW'(1));
        a_off   = (((k_ext >> layer) << layer) << 1) | pos;
        b_off   = a_off | half;
        tw_wide = (TWW'(pos) << (TWID_ADDR_SIZE - 1)) >> layer;
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state     <= IDLE;
            k         <= '0;
            layer     <= '0;
            drain_cnt <= '0;
            conj      <= 1'b0;
        end else begin
            state     <= state_nxt;
            k         <= k_nxt;
            layer     <= layer_nxt;
            drain_cnt <= drain_nxt;
            conj      <= conj_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        layer_nxt = layer;
        drain_nxt = drain_cnt;
        conj_nxt  = conj;
        rden      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_start && !bus.i_stall) begin
                    state_nxt = READ;
                    k_nxt     = '0;
                    layer_nxt = '0;
                    conj_nxt  = bus.i_inverse;
                end
            end
            READ: begin
                busy = 1'b1;
                if (!bus.i_stall) begin
                    rden = 1'b1;
                    if (k == K_LAST) begin
                        state_nxt = DRAIN;
                        drain_nxt = '0;
                    end else begin
                        k_nxt = k + 1'b1;
                    end
                end
            end
            DRAIN: begin
                // Next layer reads the bank this layer is still writing, so wait out the pipe.
                busy = 1'b1;
                if (!bus.i_stall) begin
                    if (drain_cnt == D_LAST) begin
                        if (layer == LAST_LAYER) begin
                            state_nxt = DONE;
                        end else begin
                            state_nxt = READ;
                            layer_nxt = layer + 1'b1;
                            k_nxt     = '0;
                        end
                    end else begin
                        drain_nxt = drain_cnt + 1'b1;
                    end
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
                layer_nxt = '0;
                conj_nxt  = 1'b0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wr_in = '0;
        if (rden) begin
            wr_in.vld  = 1'b1;
            wr_in.bank = ~layer[0];
            wr_in.a    = a_off;
            wr_in.b    = b_off;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            for (int i = 0; i < BFLY_LATENCY; i++) begin
                wr_pipe[i] <= '0;
            end
        end else if (!bus.i_stall) begin
            wr_pipe[0] <= wr_in;
            for (int i = 1; i < BFLY_LATENCY; i++) begin
                wr_pipe[i] <= wr_pipe[i-1];
            end
        end
    end

    assign wr_tail = wr_pipe[BFLY_LATENCY-1];

    assign bus.o_busy        = busy;
    assign bus.o_done        = done;
    assign bus.o_layer       = layer;
    assign bus.o_rden        = rden;
    assign bus.o_rdaddr_A    = (state == READ) ? {layer[0], a_off} : '0;
    assign bus.o_rdaddr_B    = (state == READ) ? {layer[0], b_off} : '0;
    assign bus.o_rdaddr_tw   = (state == READ) ? tw_wide[TWID_ADDR_SIZE-1:0] : '0;
    assign bus.o_tw_conj     = conj;
    assign bus.o_wren        = wr_tail.vld && !bus.i_stall;
    assign bus.o_wraddr_A    = {wr_tail.bank, wr_tail.a};
    assign bus.o_wraddr_B    = {wr_tail.bank, wr_tail.b};
    assign bus.o_result_bank = RESULT_BANK;
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer at N=8, BFLY_LATENCY=3: table of per-cycle
// expectations for one transform, replayed under stall, inverse, reset and stray starts.
module tb_fft_stage_sequencer;
    localparam int N  = 8;
    localparam int AW = 4;
    localparam int TW = 7;
    localparam int LW = 2;

    logic clk;
    logic rst;

    fft_stage_sequencer_if #(.FFT_SIZE(N), .ADDR_SIZE(AW), .TWID_ADDR_SIZE(TW), .LAYER_W(LW)) bus ();

    fft_stage_sequencer #(
        .FFT_SIZE(N), .ADDR_SIZE(AW), .TWID_ADDR_SIZE(TW), .BFLY_LATENCY(3), .LAYER_W(LW)
    ) dut (
        .i_CLK (clk),
        .i_RST (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic rden;
        int   ra, rb, tw;
        logic wren;
        int   wa, wb;
        logic busy, done;
        int   layer;
    } vec_t;

    vec_t tbl [24];
    int   checks;
    int   errors;

    function automatic vec_t mk(logic rden, int ra, int rb, int tw, logic wren, int wa, int wb,
                                logic busy, logic done, int layer);
        vec_t v;
        v.rden = rden; v.ra = ra; v.rb = rb; v.tw = tw;
        v.wren = wren; v.wa = wa; v.wb = wb;
        v.busy = busy; v.done = done; v.layer = layer;
        return v;
    endfunction

    task automatic chk(input string name, input int cyc, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic chk_idle(input string name, input int cyc);
        chk({name, "_busy"}, cyc, int'(bus.o_busy), 0);
        chk({name, "_done"}, cyc, int'(bus.o_done), 0);
        chk({name, "_rden"}, cyc, int'(bus.o_rden), 0);
        chk({name, "_wren"}, cyc, int'(bus.o_wren), 0);
        chk({name, "_conj"}, cyc, int'(bus.o_tw_conj), 0);
        chk({name, "_layer"}, cyc, int'(bus.o_layer), 0);
        chk({name, "_ra"}, cyc, int'(bus.o_rdaddr_A), 0);
        chk({name, "_rb"}, cyc, int'(bus.o_rdaddr_B), 0);
        chk({name, "_tw"}, cyc, int'(bus.o_rdaddr_tw), 0);
        chk({name, "_wa"}, cyc, int'(bus.o_wraddr_A), 0);
        chk({name, "_wb"}, cyc, int'(bus.o_wraddr_B), 0);
        chk({name, "_rbank"}, cyc, int'(bus.o_result_bank), 1);
    endtask

    // Runs cycles 0..last relative to the start cycle; stalled cycles map the
    // table index back by stall_len so the whole schedule slides.
    task automatic run_seq(input string name, input int stall_at, input int stall_len,
                           input logic inv, input logic extra_start, input int last);
        for (int rc = 0; rc <= last; rc++) begin
            @(posedge clk);
            #1;
            bus.i_start   = (rc == 0) || (extra_start && (rc == 5 || rc == 22));
            bus.i_stall   = (rc >= stall_at) && (rc < stall_at + stall_len);
            bus.i_inverse = inv && (rc <= 10);
            @(negedge clk);
            if (bus.i_stall) begin
                chk({name, "_stall_rden"}, rc, int'(bus.o_rden), 0);
                chk({name, "_stall_wren"}, rc, int'(bus.o_wren), 0);
                chk({name, "_stall_busy"}, rc, int'(bus.o_busy), 1);
            end else begin
                int v;
                v = (rc < stall_at) ? rc : rc - stall_len;
                chk({name, "_rden"}, rc, int'(bus.o_rden), int'(tbl[v].rden));
                chk({name, "_wren"}, rc, int'(bus.o_wren), int'(tbl[v].wren));
                chk({name, "_busy"}, rc, int'(bus.o_busy), int'(tbl[v].busy));
                chk({name, "_done"}, rc, int'(bus.o_done), int'(tbl[v].done));
                if (tbl[v].rden) begin
                    chk({name, "_ra"}, rc, int'(bus.o_rdaddr_A), tbl[v].ra);
                    chk({name, "_rb"}, rc, int'(bus.o_rdaddr_B), tbl[v].rb);
                    chk({name, "_tw"}, rc, int'(bus.o_rdaddr_tw), tbl[v].tw);
                end
                if (tbl[v].wren) begin
                    chk({name, "_wa"}, rc, int'(bus.o_wraddr_A), tbl[v].wa);
                    chk({name, "_wb"}, rc, int'(bus.o_wraddr_B), tbl[v].wb);
                end
                if (tbl[v].busy)
                    chk({name, "_layer"}, rc, int'(bus.o_layer), tbl[v].layer);
                if (v >= 1 && v <= 21)
                    chk({name, "_conj"}, rc, int'(bus.o_tw_conj), int'(inv));
                if (v == 0 || v == 23)
                    chk({name, "_conj_idle"}, rc, int'(bus.o_tw_conj), 0);
                chk({name, "_rbank"}, rc, int'(bus.o_result_bank), 1);
            end
        end
        @(posedge clk);
        #1;
        bus.i_start   = 1'b0;
        bus.i_stall   = 1'b0;
        bus.i_inverse = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        //            rden ra rb tw  wren wa wb busy done layer
        tbl[0]  = mk(0,  0, 0,  0, 0,  0,  0, 0, 0, 0);
        tbl[1]  = mk(1,  0, 1,  0, 0,  0,  0, 1, 0, 0);
        tbl[2]  = mk(1,  2, 3,  0, 0,  0,  0, 1, 0, 0);
        tbl[3]  = mk(1,  4, 5,  0, 0,  0,  0, 1, 0, 0);
        tbl[4]  = mk(1,  6, 7,  0, 1,  8,  9, 1, 0, 0);
        tbl[5]  = mk(0,  0, 0,  0, 1, 10, 11, 1, 0, 0);
        tbl[6]  = mk(0,  0, 0,  0, 1, 12, 13, 1, 0, 0);
        tbl[7]  = mk(0,  0, 0,  0, 1, 14, 15, 1, 0, 0);
        tbl[8]  = mk(1,  8, 10, 0, 0,  0,  0, 1, 0, 1);
        tbl[9]  = mk(1,  9, 11, 32, 0, 0,  0, 1, 0, 1);
        tbl[10] = mk(1, 12, 14, 0, 0,  0,  0, 1, 0, 1);
        tbl[11] = mk(1, 13, 15, 32, 1, 0,  2, 1, 0, 1);
        tbl[12] = mk(0,  0, 0,  0, 1,  1,  3, 1, 0, 1);
        tbl[13] = mk(0,  0, 0,  0, 1,  4,  6, 1, 0, 1);
        tbl[14] = mk(0,  0, 0,  0, 1,  5,  7, 1, 0, 1);
        tbl[15] = mk(1,  0, 4,  0, 0,  0,  0, 1, 0, 2);
        tbl[16] = mk(1,  1, 5, 16, 0,  0,  0, 1, 0, 2);
        tbl[17] = mk(1,  2, 6, 32, 0,  0,  0, 1, 0, 2);
        tbl[18] = mk(1,  3, 7, 48, 1,  8, 12, 1, 0, 2);
        tbl[19] = mk(0,  0, 0,  0, 1,  9, 13, 1, 0, 2);
        tbl[20] = mk(0,  0, 0,  0, 1, 10, 14, 1, 0, 2);
        tbl[21] = mk(0,  0, 0,  0, 1, 11, 15, 1, 0, 2);
        tbl[22] = mk(0,  0, 0,  0, 0,  0,  0, 0, 1, 0);
        tbl[23] = mk(0,  0, 0,  0, 0,  0,  0, 0, 0, 0);

        rst           = 1'b1;
        bus.i_start   = 1'b0;
        bus.i_stall   = 1'b0;
        bus.i_inverse = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk_idle("reset_idle", c);
        end

        run_seq("basic", 1000, 0, 1'b0, 1'b0, 23);
        run_seq("stall", 2, 2, 1'b0, 1'b0, 25);
        run_seq("inverse", 1000, 0, 1'b1, 1'b0, 23);
        run_seq("busy_start", 1000, 0, 1'b0, 1'b1, 23);

        // Reset asserted during cycle 10 of a transform.
        run_seq("pre_reset", 1000, 0, 1'b1, 1'b0, 9);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_idle("mid_reset", 11);
        run_seq("after_reset", 1000, 0, 1'b0, 1'b0, 23);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
